// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive-side frame decoder.
//   state_t              : frame FSM state encoding (2-bit)
//   SYNC_BYTE_DEFAULT    : default frame start marker
//   TIMEOUT_CLKS_DEFAULT : 4 byte-times (10 bits each) at CLKS_PER_BIT
package uart_pkg;

  typedef enum logic [1:0] {
    s_SYNC = 2'd0,
    s_CMD  = 2'd1,
    s_DATA = 2'd2,
    s_CHK  = 2'd3
  } state_t;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT    = 8'hA5;
  localparam int unsigned CLKS_PER_BIT         = 434;
  localparam int unsigned BITS_PER_BYTE        = 10;
  localparam int unsigned TIMEOUT_BYTES        = 4;
  localparam int unsigned TIMEOUT_CLKS_DEFAULT = CLKS_PER_BIT * BITS_PER_BYTE * TIMEOUT_BYTES;

endpackage

// File: rtl/uart_rx_frame_decoder_if.sv
// Byte-in / command-out bus of the frame decoder.
//   i_Rx_DV, i_Rx_Byte : byte strobe and byte from the UART receiver
//   o_Cmd_Valid        : one-cycle pulse, good frame
//   o_Cmd, o_Data      : last good CMD/DATA, held
//   o_Chk_Err          : one-cycle pulse, checksum mismatch
//   o_Timeout          : one-cycle pulse, mid-frame inter-byte timeout
//   o_Err_Count        : saturating error count
// master = byte source / command consumer, slave = decoder.
interface uart_rx_frame_decoder_if;
  logic       i_Rx_DV;
  logic [7:0] i_Rx_Byte;
  logic       o_Cmd_Valid;
  logic [7:0] o_Cmd;
  logic [7:0] o_Data;
  logic       o_Chk_Err;
  logic       o_Timeout;
  logic [7:0] o_Err_Count;

  modport master (
    output i_Rx_DV, i_Rx_Byte,
    input  o_Cmd_Valid, o_Cmd, o_Data, o_Chk_Err, o_Timeout, o_Err_Count
  );

  modport slave (
    input  i_Rx_DV, i_Rx_Byte,
    output o_Cmd_Valid, o_Cmd, o_Data, o_Chk_Err, o_Timeout, o_Err_Count
  );
endinterface

// File: rtl/uart_frame_timer.sv
// Inter-byte idle timer.
//   i_Clock, i_Reset : clock, asynchronous active-high reset
//   i_Clear          : force count to zero (has priority over i_Enable)
//   i_Enable         : count one idle clock
//   o_Terminal       : combinational; high on the enabled clock that makes
//                      the count reach TIMEOUT_CLKS
module uart_frame_timer #(
  parameter int unsigned TIMEOUT_CLKS = 17360
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Terminal
);
  localparam int unsigned W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CLKS - 1);

  logic [W-1:0] r_Count;
  logic         w_Hit;

  // Terminal is flagged one clock before the count would read TIMEOUT_CLKS
  // so the registered pulse downstream lands on the reaching cycle.
  assign w_Hit      = i_Enable && !i_Clear && (r_Count == LAST);
  assign o_Terminal = w_Hit;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Count <= '0;
    end else if (i_Clear || w_Hit) begin
      r_Count <= '0;
    end else if (i_Enable) begin
      r_Count <= r_Count + W'(1);
    end
  end
endmodule

// File: rtl/uart_rx_frame_decoder.sv
// Frames the UART byte stream into SYNC/CMD/DATA/CHK commands.
//   i_Clock : sole clock
//   i_Reset : asynchronous active-high reset
//   bus     : byte input and registered command/error outputs
// CHK must equal CMD xor DATA. Bad checksums and mid-frame timeouts each
// pulse a flag and bump a count saturating at 255.
module uart_rx_frame_decoder
  import uart_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CLKS = TIMEOUT_CLKS_DEFAULT
) (
  input logic                    i_Clock,
  input logic                    i_Reset,
  uart_rx_frame_decoder_if.slave bus
);
  state_t     r_State;
  state_t     w_Next;
  logic [7:0] r_Cmd;
  logic [7:0] r_Data;
  logic       w_Latch_Cmd;
  logic       w_Latch_Data;
  logic       w_Good;
  logic       w_Bad;
  logic       w_Timeout;
  logic       w_Tc;
  logic       w_Timer_Clear;
  logic       w_Timer_En;

  assign w_Timer_Clear = bus.i_Rx_DV || (r_State == s_SYNC);
  assign w_Timer_En    = (r_State != s_SYNC);

  uart_frame_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timer (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_Clear   (w_Timer_Clear),
    .i_Enable  (w_Timer_En),
    .o_Terminal(w_Tc)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) r_State <= s_SYNC;
    else         r_State <= w_Next;
  end

  always_comb begin
    w_Next       = r_State;
    w_Latch_Cmd  = 1'b0;
    w_Latch_Data = 1'b0;
    w_Good       = 1'b0;
    w_Bad        = 1'b0;
    w_Timeout    = 1'b0;
    case (r_State)
      s_SYNC: begin
        if (bus.i_Rx_DV && (bus.i_Rx_Byte == SYNC_BYTE)) w_Next = s_CMD;
      end
      s_CMD: begin
        if (bus.i_Rx_DV) begin
          w_Latch_Cmd = 1'b1;
          w_Next      = s_DATA;
        end else if (w_Tc) begin
          w_Timeout = 1'b1;
          w_Next    = s_SYNC;
        end
      end
      s_DATA: begin
        if (bus.i_Rx_DV) begin
          w_Latch_Data = 1'b1;
          w_Next       = s_CHK;
        end else if (w_Tc) begin
          w_Timeout = 1'b1;
          w_Next    = s_SYNC;
        end
      end
      s_CHK: begin
        if (bus.i_Rx_DV) begin
          if (bus.i_Rx_Byte == (r_Cmd ^ r_Data)) w_Good = 1'b1;
          else                                   w_Bad  = 1'b1;
          w_Next = s_SYNC;
        end else if (w_Tc) begin
          w_Timeout = 1'b1;
          w_Next    = s_SYNC;
        end
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Cmd           <= '0;
      r_Data          <= '0;
      bus.o_Cmd_Valid <= 1'b0;
      bus.o_Cmd       <= '0;
      bus.o_Data      <= '0;
      bus.o_Chk_Err   <= 1'b0;
      bus.o_Timeout   <= 1'b0;
      bus.o_Err_Count <= '0;
    end else begin
      if (w_Latch_Cmd)  r_Cmd  <= bus.i_Rx_Byte;
      if (w_Latch_Data) r_Data <= bus.i_Rx_Byte;
      if (w_Good) begin
        bus.o_Cmd  <= r_Cmd;
        bus.o_Data <= r_Data;
      end
      bus.o_Cmd_Valid <= w_Good;
      bus.o_Chk_Err   <= w_Bad;
      bus.o_Timeout   <= w_Timeout;
      if ((w_Bad || w_Timeout) && (bus.o_Err_Count != 8'hFF))
        bus.o_Err_Count <= bus.o_Err_Count + 8'd1;
    end
  end
endmodule

// File: tb/tb_uart_rx_frame_decoder.sv
// Self-checking bench for uart_rx_frame_decoder: a byte-queue frame model
// predicts every output each cycle; directed literals pin the model.
module tb_uart_rx_frame_decoder;
  localparam int unsigned T = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_frame_decoder_if bus ();

  uart_rx_frame_decoder #(
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CLKS(T)
  ) dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] frame[$];
  int         idle = 0;
  logic       m_valid = 1'b0, m_chk = 1'b0, m_to = 1'b0;
  logic [7:0] m_cmd = '0, m_data = '0;
  int         m_err = 0;

  function automatic void bump();
    if (m_err < 255) m_err++;
  endfunction

  always @(posedge clk) begin
    m_valid = 1'b0;
    m_chk   = 1'b0;
    m_to    = 1'b0;
    if (rst) begin
      frame.delete();
      idle   = 0;
      m_cmd  = '0;
      m_data = '0;
      m_err  = 0;
    end else if (bus.i_Rx_DV) begin
      idle = 0;
      if (frame.size() != 0 || bus.i_Rx_Byte == 8'hA5) frame.push_back(bus.i_Rx_Byte);
      if (frame.size() == 4) begin
        if (frame[3] == (frame[1] ^ frame[2])) begin
          m_valid = 1'b1;
          m_cmd   = frame[1];
          m_data  = frame[2];
        end else begin
          m_chk = 1'b1;
          bump();
        end
        frame.delete();
      end
    end else if (frame.size() != 0) begin
      idle++;
      if (idle == T) begin
        m_to = 1'b1;
        bump();
        frame.delete();
        idle = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("valid", 32'(bus.o_Cmd_Valid), 32'(m_valid));
      check("chk_err", 32'(bus.o_Chk_Err), 32'(m_chk));
      check("timeout", 32'(bus.o_Timeout), 32'(m_to));
      check("cmd", 32'(bus.o_Cmd), 32'(m_cmd));
      check("data", 32'(bus.o_Data), 32'(m_data));
      check("err_count", 32'(bus.o_Err_Count), 32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  // All drives happen 1 time unit after a rising edge.
  task automatic send(input logic [7:0] b);
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = b;
    @(posedge clk);
    #1;
    bus.i_Rx_DV   = 1'b0;
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int cnt;
    bus.i_Rx_DV   = 1'b0;
    bus.i_Rx_Byte = '0;
    @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.o_Cmd_Valid), 32'd0);
    check("rst_err", 32'(bus.o_Err_Count), 32'd0);
    rst = 1'b0;
    wait_cycles(2);

    // good frame
    send4(8'hA5, 8'h01, 8'h7F, 8'h7E);
    check("t1_valid", 32'(bus.o_Cmd_Valid), 32'd1);
    check("t1_cmd", 32'(bus.o_Cmd), 32'h01);
    check("t1_data", 32'(bus.o_Data), 32'h7F);
    check("t1_err", 32'(bus.o_Err_Count), 32'd0);
    wait_cycles(1);
    check("t1_pulse_once", 32'(bus.o_Cmd_Valid), 32'd0);

    // bad checksum
    send4(8'hA5, 8'h02, 8'h10, 8'h00);
    check("t2_chk", 32'(bus.o_Chk_Err), 32'd1);
    check("t2_err", 32'(bus.o_Err_Count), 32'd1);
    check("t2_cmd_held", 32'(bus.o_Cmd), 32'h01);
    check("t2_data_held", 32'(bus.o_Data), 32'h7F);
    wait_cycles(3);

    // leading junk, then good frame (back-to-back bytes)
    send(8'h00); send(8'hFF); send(8'h3C);
    send4(8'hA5, 8'h03, 8'h05, 8'h06);
    check("t3_valid", 32'(bus.o_Cmd_Valid), 32'd1);
    check("t3_cmd", 32'(bus.o_Cmd), 32'h03);
    check("t3_data", 32'(bus.o_Data), 32'h05);
    check("t3_err", 32'(bus.o_Err_Count), 32'd1);
    wait_cycles(2);

    // timeout after partial frame
    send(8'hA5); send(8'h04);
    cnt = 0;
    while (!bus.o_Timeout && cnt < int'(T) + 5) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("t4_timeout_cycle", 32'(cnt), 32'(T));
    check("t4_err", 32'(bus.o_Err_Count), 32'd2);
    wait_cycles(1);
    check("t4_pulse_once", 32'(bus.o_Timeout), 32'd0);
    send4(8'hA5, 8'h04, 8'h10, 8'h14);
    check("t4_valid", 32'(bus.o_Cmd_Valid), 32'd1);
    check("t4_cmd", 32'(bus.o_Cmd), 32'h04);
    check("t4_data", 32'(bus.o_Data), 32'h10);
    wait_cycles(2);

    // reset mid-frame
    send(8'hA5); send(8'h06);
    rst = 1'b1;
    #1;
    check("t5_rst_cmd", 32'(bus.o_Cmd), 32'd0);
    check("t5_rst_err", 32'(bus.o_Err_Count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h07); send(8'h08); send(8'h0F);
    check("t5_no_valid", 32'(bus.o_Cmd_Valid), 32'd0);
    check("t5_no_chk", 32'(bus.o_Chk_Err), 32'd0);
    check("t5_cmd0", 32'(bus.o_Cmd), 32'd0);
    send4(8'hA5, 8'h07, 8'h08, 8'h0F);
    check("t5_valid", 32'(bus.o_Cmd_Valid), 32'd1);
    check("t5_cmd", 32'(bus.o_Cmd), 32'h07);
    check("t5_data", 32'(bus.o_Data), 32'h08);

    // saturation
    for (int i = 0; i < 300; i++) begin
      send4(8'hA5, 8'h01, 8'h01, 8'h01);
      if (i == 254) check("t6_err_255", 32'(bus.o_Err_Count), 32'd255);
    end
    check("t6_err_sat", 32'(bus.o_Err_Count), 32'd255);
    check("t6_cmd_held", 32'(bus.o_Cmd), 32'h07);
    wait_cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
